// File: rtl/avl_arb_pkg.sv
// Shared types and width constants for the Avalon insn/data port arbiter.
package avl_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
    typedef enum logic {G_INSN, G_DATA} grant_t;

    localparam int LANE_W   = 2;
    localparam int MEM_BE_W = 16;
    localparam int DATA_W   = 32;
    localparam int MEM_W    = 128;
endpackage

// File: rtl/arb_rr2.sv
// Two-way pick between insn and data with a last-grant register.
module arb_rr2
    import avl_arb_pkg::*;
#(
    parameter int ARB_MODE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic req_insn_i,
    input  logic req_data_i,
    input  logic take_i,
    output logic gnt_data_o,
    output logic any_o
);
    grant_t last_q, gnt;

    always_comb begin
        gnt = G_INSN;
        if (req_insn_i && req_data_i) begin
            if (ARB_MODE == 1) gnt = G_DATA;
            else               gnt = (last_q == G_DATA) ? G_INSN : G_DATA;
        end else if (req_data_i) begin
            gnt = G_DATA;
        end
    end

    // Last grant starts at DATA so insn wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    last_q <= G_DATA;
        else if (take_i && any_o)   last_q <= gnt;
    end

    assign gnt_data_o = (gnt == G_DATA);
    assign any_o      = req_insn_i || req_data_i;
endmodule

// File: rtl/avl_port_arbiter.sv
// Shares one 128-bit Avalon agent between a 128-bit insn host and a 32-bit data host,
// with lane steering and a stall watchdog.
module avl_port_arbiter
    import avl_arb_pkg::*;
#(
    parameter int          ARB_MODE  = 0,
    parameter int          TIMEOUT   = 1023,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  avl_insn_address,
    input  logic         avl_insn_read,
    output logic [127:0] avl_insn_readdata,
    output logic         avl_insn_waitrequest,
    input  logic [31:0]  avl_data_address,
    input  logic         avl_data_read,
    input  logic         avl_data_write,
    input  logic [31:0]  avl_data_writedata,
    input  logic [3:0]   avl_data_byteenable,
    output logic [31:0]  avl_data_readdata,
    output logic         avl_data_waitrequest,
    output logic [31:0]  avl_mem_address,
    output logic         avl_mem_read,
    output logic         avl_mem_write,
    output logic [127:0] avl_mem_writedata,
    output logic [15:0]  avl_mem_byteenable,
    input  logic [127:0] avl_mem_readdata,
    input  logic         avl_mem_waitrequest,
    output logic         timeout_err
);
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t             state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic                   rd_q, rd_d, wr_q, wr_d;
    logic [MEM_W-1:0]       wdata_q, wdata_d;
    logic [MEM_BE_W-1:0]    be_q, be_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [WD_W-1:0]        wdog_q, wdog_d;
    logic                   err_q, err_d;
    logic                   gnt_data, any_req, busy, mem_done, wd_abort, fin;
    logic                   unused_addr_bits;

    arb_rr2 #(.ARB_MODE(ARB_MODE)) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_insn_i (avl_insn_read),
        .req_data_i (avl_data_read || avl_data_write),
        .take_i     (state_q == IDLE),
        .gnt_data_o (gnt_data),
        .any_o      (any_req)
    );

    assign busy     = (state_q != IDLE);
    assign mem_done = busy && !avl_mem_waitrequest;
    // A genuine completion in the limit cycle beats the abort.
    assign wd_abort = (TIMEOUT > 0) && busy && avl_mem_waitrequest &&
                      (wdog_q == WD_W'(TIMEOUT));
    assign fin      = mem_done || wd_abort;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        lane_d  = lane_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    wdog_d = '0;
                    if (gnt_data) begin
                        addr_d  = {avl_data_address[31:4], 4'b0};
                        lane_d  = avl_data_address[3:2];
                        rd_d    = !avl_data_write;
                        wr_d    = avl_data_write;
                        wdata_d = {4{avl_data_writedata}};
                        be_d    = {12'b0, (avl_data_write ? avl_data_byteenable : 4'hF)}
                                  << {avl_data_address[3:2], 2'b00};
                        state_d = BUSY_D;
                    end else begin
                        addr_d  = {avl_insn_address[31:4], 4'b0};
                        rd_d    = 1'b1;
                        wr_d    = 1'b0;
                        wdata_d = '0;
                        be_d    = 16'hFFFF;
                        state_d = BUSY_I;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (fin) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = IDLE;
                    if (wd_abort) err_d = 1'b1;
                end else if (TIMEOUT > 0 && avl_mem_waitrequest &&
                             wdog_q != WD_W'(TIMEOUT)) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            lane_q  <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            lane_q  <= lane_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    assign avl_mem_address    = addr_q;
    assign avl_mem_read       = rd_q;
    assign avl_mem_write      = wr_q;
    assign avl_mem_writedata  = wdata_q;
    assign avl_mem_byteenable = be_q;
    assign timeout_err        = err_q;

    assign avl_insn_waitrequest = !((state_q == BUSY_I) && fin);
    assign avl_data_waitrequest = !((state_q == BUSY_D) && fin);
    assign avl_insn_readdata    = wd_abort ? {4{ERR_RDATA}} : avl_mem_readdata;
    assign avl_data_readdata    = wd_abort ? ERR_RDATA : avl_mem_readdata[32*lane_q +: 32];

    assign unused_addr_bits = ^{avl_insn_address[3:0], avl_data_address[1:0]};
endmodule

// File: tb/tb_avl_port_arbiter.sv
// Directed bench: round-robin instance u0 and fixed-priority instance u1 share stimulus.
module tb_avl_port_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  insn_addr, data_addr, data_wdata;
    logic         insn_read, data_read, data_write, mem_wait;
    logic [3:0]   data_be;
    logic [127:0] mem_rdata;

    logic [127:0] i_rdata0, i_rdata1, m_wdata0, m_wdata1;
    logic         i_wait0, i_wait1, d_wait0, d_wait1;
    logic [31:0]  d_rdata0, d_rdata1, m_addr0, m_addr1;
    logic         m_rd0, m_rd1, m_wr0, m_wr1, terr0, terr1;
    logic [15:0]  m_be0, m_be1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    avl_port_arbiter #(.ARB_MODE(0), .TIMEOUT(8)) u0 (
        .clk(clk), .rst(rst),
        .avl_insn_address(insn_addr), .avl_insn_read(insn_read),
        .avl_insn_readdata(i_rdata0), .avl_insn_waitrequest(i_wait0),
        .avl_data_address(data_addr), .avl_data_read(data_read), .avl_data_write(data_write),
        .avl_data_writedata(data_wdata), .avl_data_byteenable(data_be),
        .avl_data_readdata(d_rdata0), .avl_data_waitrequest(d_wait0),
        .avl_mem_address(m_addr0), .avl_mem_read(m_rd0), .avl_mem_write(m_wr0),
        .avl_mem_writedata(m_wdata0), .avl_mem_byteenable(m_be0),
        .avl_mem_readdata(mem_rdata), .avl_mem_waitrequest(mem_wait),
        .timeout_err(terr0));

    avl_port_arbiter #(.ARB_MODE(1), .TIMEOUT(8)) u1 (
        .clk(clk), .rst(rst),
        .avl_insn_address(insn_addr), .avl_insn_read(insn_read),
        .avl_insn_readdata(i_rdata1), .avl_insn_waitrequest(i_wait1),
        .avl_data_address(data_addr), .avl_data_read(data_read), .avl_data_write(data_write),
        .avl_data_writedata(data_wdata), .avl_data_byteenable(data_be),
        .avl_data_readdata(d_rdata1), .avl_data_waitrequest(d_wait1),
        .avl_mem_address(m_addr1), .avl_mem_read(m_rd1), .avl_mem_write(m_wr1),
        .avl_mem_writedata(m_wdata1), .avl_mem_byteenable(m_be1),
        .avl_mem_readdata(mem_rdata), .avl_mem_waitrequest(mem_wait),
        .timeout_err(terr1));

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        insn_addr = 0; data_addr = 0; data_wdata = 0; data_be = 0;
        insn_read = 0; data_read = 0; data_write = 0; mem_wait = 1; mem_rdata = '0;
        rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vectors++;
        if ({m_rd0, m_wr0, m_addr0, m_be0, m_wdata0, terr0} !== '0) begin
            miscompares++;
            $display("FAIL reset_mem rd=%b wr=%b addr=%h be=%h err=%b required all 0",
                     m_rd0, m_wr0, m_addr0, m_be0, terr0);
        end
        vectors++;
        if ({i_wait0, d_wait0} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_wait got %b%b required 11", i_wait0, d_wait0);
        end
    endtask

    task automatic test_insn_read();
        do_reset();
        insn_read = 1; insn_addr = 32'h0000_1238;
        tick();
        @(negedge clk);
        vectors++;
        if (m_addr0 !== 32'h1230 || m_rd0 !== 1 || m_be0 !== 16'hFFFF || i_wait0 !== 1) begin
            miscompares++;
            $display("FAIL insn_grant addr=%h rd=%b be=%h wait=%b required 1230/1/ffff/1",
                     m_addr0, m_rd0, m_be0, i_wait0);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (i_wait0 !== 1) begin
            miscompares++;
            $display("FAIL insn_stall wait=%b required 1", i_wait0);
        end
        mem_wait = 0; mem_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        #1;
        vectors++;
        if (i_wait0 !== 0 || i_rdata0 !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210
            || d_wait0 !== 1) begin
            miscompares++;
            $display("FAIL insn_done wait=%b dwait=%b rdata=%h required 0/1/pass-through",
                     i_wait0, d_wait0, i_rdata0);
        end
        tick();
        insn_read = 0; mem_wait = 1;
        @(negedge clk);
        vectors++;
        if (m_rd0 !== 0 || i_wait0 !== 1) begin
            miscompares++;
            $display("FAIL insn_drop rd=%b wait=%b required 0/1", m_rd0, i_wait0);
        end
    endtask

    task automatic test_data_write();
        do_reset();
        data_write = 1; data_addr = 32'h104; data_wdata = 32'hA5A5_0001; data_be = 4'b0011;
        mem_wait = 0;
        tick();
        @(negedge clk);
        vectors++;
        if (m_addr0 !== 32'h100 || m_wr0 !== 1 || m_rd0 !== 0 || m_be0 !== 16'h0030 ||
            m_wdata0 !== {4{32'hA5A5_0001}} || d_wait0 !== 0) begin
            miscompares++;
            $display("FAIL data_write addr=%h wr=%b rd=%b be=%h wd=%h wait=%b required 100/1/0/0030/rep/0",
                     m_addr0, m_wr0, m_rd0, m_be0, m_wdata0, d_wait0);
        end
        tick();
        data_write = 0;
        @(negedge clk);
        vectors++;
        if (m_wr0 !== 0 || d_wait0 !== 1) begin
            miscompares++;
            $display("FAIL data_write_drop wr=%b wait=%b required 0/1", m_wr0, d_wait0);
        end
    endtask

    task automatic test_data_read();
        do_reset();
        data_read = 1; data_write = 1; data_addr = 32'h10C; data_be = 4'b0001;
        data_wdata = 32'h1;
        mem_rdata = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        mem_wait = 0;
        // read+write together behaves as a write
        tick();
        @(negedge clk);
        vectors++;
        if (m_wr0 !== 1 || m_rd0 !== 0 || m_be0 !== 16'h1000) begin
            miscompares++;
            $display("FAIL data_rw_is_write wr=%b rd=%b be=%h required 1/0/1000",
                     m_wr0, m_rd0, m_be0);
        end
        tick();
        data_write = 0;
        tick();
        @(negedge clk);
        vectors++;
        if (m_rd0 !== 1 || m_be0 !== 16'hF000 || d_rdata0 !== 32'h4444_4444 || d_wait0 !== 0) begin
            miscompares++;
            $display("FAIL data_read rd=%b be=%h rdata=%h wait=%b required 1/f000/44444444/0",
                     m_rd0, m_be0, d_rdata0, d_wait0);
        end
        tick();
        data_read = 0;
    endtask

    task automatic test_arbitration();
        logic [3:0] exp_i;
        exp_i = 4'b0101;
        do_reset();
        insn_read = 1; data_read = 1; insn_addr = 32'h200; data_addr = 32'h300; mem_wait = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            vectors++;
            if (i_wait0 !== !exp_i[k] || d_wait0 !== exp_i[k]) begin
                miscompares++;
                $display("FAIL rr_grant%0d iwait=%b dwait=%b required %b/%b",
                         k, i_wait0, d_wait0, !exp_i[k], exp_i[k]);
            end
            vectors++;
            if (i_wait1 !== 1 || d_wait1 !== 0) begin
                miscompares++;
                $display("FAIL prio_grant%0d iwait=%b dwait=%b required 1/0", k, i_wait1, d_wait1);
            end
            tick();
        end
        data_read = 0;
        tick();
        @(negedge clk);
        vectors++;
        if (i_wait1 !== 0 || m_addr1 !== 32'h200) begin
            miscompares++;
            $display("FAIL prio_insn_when_idle iwait=%b addr=%h required 0/200", i_wait1, m_addr1);
        end
        tick();
        insn_read = 0;
    endtask

    task automatic test_timeout();
        int stalls;
        bit done;
        do_reset();
        data_read = 1; data_addr = 32'h108; mem_wait = 1;
        mem_rdata = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        tick();
        stalls = 0; done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (d_wait0 === 0) begin
                done = 1;
                vectors++;
                if (d_rdata0 !== 32'hDEADBEEF) begin
                    miscompares++;
                    $display("FAIL timeout_rdata got %h required deadbeef", d_rdata0);
                end
            end else begin
                stalls++;
            end
            tick();
        end
        vectors++;
        if (!done || stalls != 8) begin
            miscompares++;
            $display("FAIL timeout_stalls done=%b stalls=%0d required 1/8", done, stalls);
        end
        data_read = 0;
        @(negedge clk);
        vectors++;
        if (terr0 !== 1 || m_rd0 !== 0) begin
            miscompares++;
            $display("FAIL timeout_err err=%b rd=%b required 1/0", terr0, m_rd0);
        end
        insn_read = 1; insn_addr = 32'h40; mem_wait = 0;
        tick();
        @(negedge clk);
        vectors++;
        if (i_wait0 !== 0 || i_rdata0 !== mem_rdata || terr0 !== 1) begin
            miscompares++;
            $display("FAIL after_timeout iwait=%b rdata=%h err=%b required 0/mem/1",
                     i_wait0, i_rdata0, terr0);
        end
        tick();
        insn_read = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        data_read = 1; data_addr = 32'h500; mem_wait = 1;
        tick();
        @(negedge clk);
        vectors++;
        if (m_rd0 !== 1 || m_addr0 !== 32'h500) begin
            miscompares++;
            $display("FAIL mid_busy rd=%b addr=%h required 1/500", m_rd0, m_addr0);
        end
        rst = 1; data_read = 0;
        #1;
        vectors++;
        if ({m_rd0, m_wr0, m_addr0, m_be0} !== '0 || d_wait0 !== 1) begin
            miscompares++;
            $display("FAIL mid_reset rd=%b addr=%h be=%h dwait=%b required 0/0/0/1",
                     m_rd0, m_addr0, m_be0, d_wait0);
        end
        tick();
        rst = 0;
        insn_read = 1; insn_addr = 32'h604; mem_wait = 0;
        tick();
        @(negedge clk);
        vectors++;
        if (m_rd0 !== 1 || m_addr0 !== 32'h600 || i_wait0 !== 0) begin
            miscompares++;
            $display("FAIL post_reset_grant rd=%b addr=%h iwait=%b required 1/600/0",
                     m_rd0, m_addr0, i_wait0);
        end
        tick();
        insn_read = 0;
    endtask

    initial begin
        test_reset();
        test_insn_read();
        test_data_write();
        test_data_read();
        test_arbitration();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
